univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 9 +
 rtl/univ_shift_reg_shift_cnt_sat.sv | 21 ++
 rtl/univ_shift_reg.sv | 76 +++++++
 tb/tb_univ_shift_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register: mode select encodings.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg_shift_cnt_sat.sv
// Saturating up-counter: clear wins over increment, and the count sticks at MAX.
module shift_cnt_sat #(
    parameter int MAX   = 8,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(MAX))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (serial fill or rotate), parallel load,
// plus a saturating count of shifts since the last load or reset.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               ROTATE  = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       ser_in_msb,
    input  logic                       ser_in_lsb,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
    output logic                       ser_out_lsb,
    output logic                       ser_out_msb,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       drained
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_next;
    logic             msb_fill;
    logic             lsb_fill;
    logic             do_load;
    logic             do_shift;

    // Rotation feeds the bit falling off the opposite end back in; serial pins are then unused.
    assign msb_fill = (ROTATE != 0) ? q[0]       : ser_in_msb;
    assign lsb_fill = (ROTATE != 0) ? q[WIDTH-1] : ser_in_lsb;

    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_SHR:  q_next = {msb_fill, q[WIDTH-1:1]};
                MODE_SHL:  q_next = {q[WIDTH-2:0], lsb_fill};
                MODE_LOAD: q_next = d_in;
                default:   q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

    assign do_load  = en && (mode == MODE_LOAD);
    assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

    shift_cnt_sat #(
        .MAX   (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (do_load),
        .inc   (do_shift),
        .cnt   (shift_cnt)
    );

    assign qb          = ~q;
    assign ser_out_lsb = q[0];
    assign ser_out_msb = q[WIDTH-1];
    assign drained     = (shift_cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: two instances (serial-fill and rotate) share stimulus; a queue of
// expected states is filled by the driver and drained by an independent monitor.
module tb_univ_shift_reg;

    localparam int         W   = 8;
    localparam logic [7:0] RSV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d_in = 8'h00;
    logic       ser_in_msb = 1'b0;
    logic       ser_in_lsb = 1'b0;

    logic [7:0] q0, qb0, q1, qb1;
    logic       sol0, som0, sol1, som1, dr0, dr1;
    logic [3:0] cnt0, cnt1;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .ROTATE(0), .RST_VAL(RSV)) dut_ser (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb),
        .q(q0), .qb(qb0), .ser_out_lsb(sol0), .ser_out_msb(som0),
        .shift_cnt(cnt0), .drained(dr0)
    );

    univ_shift_reg #(.WIDTH(W), .ROTATE(1), .RST_VAL(RSV)) dut_rot (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb),
        .q(q1), .qb(qb1), .ser_out_lsb(sol1), .ser_out_msb(som1),
        .shift_cnt(cnt1), .drained(dr1)
    );

    typedef struct {
        int unsigned q_ser;
        int unsigned q_rot;
        int          c_ser;
        int          c_rot;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    int          tests = 0;
    int          fails = 0;
    int unsigned m_ser = 0;
    int unsigned m_rot = 0;
    int          mc_ser = 0;
    int          mc_rot = 0;
    bit          done = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain arithmetic on integers, applied at each clock edge.
    task automatic step(input bit r, input bit e, input bit [1:0] m, input bit [7:0] d,
                        input bit smsb, input bit slsb, input string tag);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; d_in = d; ser_in_msb = smsb; ser_in_lsb = slsb;
        if (r) begin
            m_ser = RSV; m_rot = RSV; mc_ser = 0; mc_rot = 0;
        end else if (e && m == 2'd3) begin
            m_ser = d; m_rot = d; mc_ser = 0; mc_rot = 0;
        end else if (e && m == 2'd1) begin
            m_ser = (m_ser >> 1) + (smsb ? 128 : 0);
            m_rot = (m_rot >> 1) + ((m_rot % 2) * 128);
            mc_ser = (mc_ser < W) ? mc_ser + 1 : W;
            mc_rot = (mc_rot < W) ? mc_rot + 1 : W;
        end else if (e && m == 2'd2) begin
            m_ser = ((m_ser * 2) % 256) + (slsb ? 1 : 0);
            m_rot = ((m_rot * 2) % 256) + (m_rot / 128);
            mc_ser = (mc_ser < W) ? mc_ser + 1 : W;
            mc_rot = (mc_rot < W) ? mc_rot + 1 : W;
        end
        x.q_ser = m_ser; x.q_rot = m_rot; x.c_ser = mc_ser; x.c_rot = mc_rot;
        sb.push_back(x);
        tags.push_back(tag);
    endtask

    // Monitor: after each edge, compare the DUT state against the oldest pending expectation.
    initial begin
        exp_t  x;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                t = tags.pop_front();
                check({t, " q_ser"},   q0,   x.q_ser);
                check({t, " qb_ser"},  qb0,  (~x.q_ser) & 8'hFF);
                check({t, " lsb_ser"}, sol0, x.q_ser % 2);
                check({t, " msb_ser"}, som0, x.q_ser / 128);
                check({t, " cnt_ser"}, cnt0, x.c_ser);
                check({t, " drn_ser"}, dr0,  (x.c_ser == W) ? 1 : 0);
                check({t, " q_rot"},   q1,   x.q_rot);
                check({t, " qb_rot"},  qb1,  (~x.q_rot) & 8'hFF);
                check({t, " lsb_rot"}, sol1, x.q_rot % 2);
                check({t, " msb_rot"}, som1, x.q_rot / 128);
                check({t, " cnt_rot"}, cnt1, x.c_rot);
                check({t, " drn_rot"}, dr1,  (x.c_rot == W) ? 1 : 0);
            end
        end
    end

    initial begin
        int budget;
        // Reset state
        step(1, 0, 2'd0, 8'h00, 0, 0, "reset");
        // Load then serial right shifts with ones
        step(0, 1, 2'd3, 8'hB4, 0, 0, "load_b4");
        for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 8'h00, 1, 0, "shr_fill1");
        // Rotate left eight times from 0x81
        step(0, 1, 2'd3, 8'h81, 0, 0, "load_81");
        for (int i = 0; i < 8; i++) step(0, 1, 2'd2, 8'h00, 0, 1, "shl");
        // Saturation beyond WIDTH shifts, then reload clears count
        step(0, 1, 2'd3, 8'hFF, 0, 0, "load_ff");
        for (int i = 0; i < 10; i++) step(0, 1, 2'd1, 8'h00, 0, 0, "shr_sat");
        step(0, 1, 2'd3, 8'h5A, 0, 0, "reload");
        // Enable low and hold mode
        step(0, 1, 2'd3, 8'h3C, 0, 0, "load_3c");
        for (int i = 0; i < 4; i++) step(0, 0, 2'd1, 8'h00, 1, 1, "en_low");
        step(0, 1, 2'd0, 8'hFF, 1, 1, "hold");
        // Alternating directions both count
        for (int i = 0; i < 4; i++) step(0, 1, (i % 2) ? 2'd1 : 2'd2, 8'h00, 1, 0, "alt");
        // Reset beats a concurrent load
        step(0, 1, 2'd2, 8'h00, 1, 1, "pre_rst");
        step(1, 1, 2'd3, 8'hFF, 1, 1, "rst_prio");
        step(0, 1, 2'd1, 8'h00, 0, 0, "post_rst");
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
